// File: rtl/red_pitaya_na_pkg.sv
// Shared definitions for the network-analyzer sweep controller:
// IQ register offsets, slave register map and sequencer state encoding.
package red_pitaya_na_pkg;

    localparam logic [15:0] IQ_REG_FREQ   = 16'h0108;
    localparam logic [15:0] IQ_REG_SUM_IL = 16'h0140;
    localparam logic [15:0] IQ_REG_SUM_IH = 16'h0144;
    localparam logic [15:0] IQ_REG_SUM_QL = 16'h0148;
    localparam logic [15:0] IQ_REG_SUM_QH = 16'h014C;

    localparam logic [15:0] SL_CTRL    = 16'h0000;
    localparam logic [15:0] SL_STATUS  = 16'h0004;
    localparam logic [15:0] SL_START   = 16'h0008;
    localparam logic [15:0] SL_STEP    = 16'h000C;
    localparam logic [15:0] SL_POINTS  = 16'h0010;
    localparam logic [15:0] SL_CUR_IDX = 16'h0014;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SETF = 3'd1,
        S_POLL = 3'd2,
        S_RIH  = 3'd3,
        S_RQL  = 3'd4,
        S_RQH  = 3'd5,
        S_PUSH = 3'd6,
        S_NEXT = 3'd7
    } na_state_t;

    // IQ register touched by each bus-transaction state.
    function automatic logic [15:0] na_iq_addr(input na_state_t s);
        case (s)
            S_SETF:  return IQ_REG_FREQ;
            S_POLL:  return IQ_REG_SUM_IL;
            S_RIH:   return IQ_REG_SUM_IH;
            S_RQL:   return IQ_REG_SUM_QL;
            S_RQH:   return IQ_REG_SUM_QH;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/red_pitaya_na_bus_master.sv
// Single-outstanding master on the IQ register bus: one-cycle strobe,
// address/data held until ack, ack data capture and a no-ack timeout.
module red_pitaya_na_bus_master #(
    parameter int TOBITS = 8
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        i_req_wr,
    input  logic        i_req_rd,
    input  logic [15:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_done,
    output logic        o_timeout,
    output logic [31:0] o_rdata,
    output logic [15:0] o_iq_addr,
    output logic        o_iq_wen,
    output logic        o_iq_ren,
    output logic [31:0] o_iq_wdata,
    input  logic        i_iq_ack,
    input  logic [31:0] i_iq_rdata
);

    logic              r_busy;
    logic [TOBITS-1:0] r_tmo_cnt;
    logic              r_wen;
    logic              r_ren;
    logic [15:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic              r_timeout;
    logic [31:0]       r_rdata;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_busy    <= 1'b0;
            r_tmo_cnt <= '0;
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            if (!r_busy) begin
                if (i_req_wr || i_req_rd) begin
                    r_wen     <= i_req_wr;
                    r_ren     <= i_req_rd && !i_req_wr;
                    r_addr    <= i_req_addr;
                    r_wdata   <= i_req_wdata;
                    r_busy    <= 1'b1;
                    r_tmo_cnt <= '1;
                end
            end else if (i_iq_ack) begin
                r_rdata <= i_iq_rdata;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
            end else if (r_tmo_cnt == TOBITS'(1)) begin
                // the strobe cycle counts as the first waited cycle
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
                r_busy    <= 1'b0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt - TOBITS'(1);
            end
        end
    end

    assign o_done     = r_done;
    assign o_timeout  = r_timeout;
    assign o_rdata    = r_rdata;
    assign o_iq_addr  = r_addr;
    assign o_iq_wen   = r_wen;
    assign o_iq_ren   = r_ren;
    assign o_iq_wdata = r_wdata;

endmodule

// File: rtl/red_pitaya_na_sweep_ctrl.sv
// Network-analyzer sweep sequencer: PS-configured, drives one IQ block over
// its register bus and streams reassembled I/Q sums per frequency point.
//
// state | meaning
// IDLE  | waiting for start
// SETF  | write phase increment to 0x108 (re-arms averager)
// POLL  | read 0x140 until do_averaging clears, keep I low
// RIH   | read 0x144, I high
// RQL   | read 0x148, Q low
// RQH   | read 0x14C, Q high
// PUSH  | hold result beat until accepted
// NEXT  | advance index/frequency, finish or loop
module red_pitaya_na_sweep_ctrl
    import red_pitaya_na_pkg::*;
#(
    parameter int PHASEBITS = 32,
    parameter int SUMBITS   = 62,
    parameter int PTBITS    = 16,
    parameter int TOBITS    = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [15:0]        addr,
    input  logic               wen,
    input  logic               ren,
    input  logic [31:0]        wdata,
    output logic               ack,
    output logic [31:0]        rdata,
    output logic [15:0]        iq_addr,
    output logic               iq_wen,
    output logic               iq_ren,
    output logic [31:0]        iq_wdata,
    input  logic               iq_ack,
    input  logic [31:0]        iq_rdata,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SUMBITS-1:0] res_i,
    output logic [SUMBITS-1:0] res_q,
    output logic [PTBITS-1:0]  res_idx,
    output logic               busy_o
);

    na_state_t             r_state;
    logic [PHASEBITS-1:0]  r_start_freq;
    logic [PHASEBITS-1:0]  r_step_freq;
    logic [PTBITS-1:0]     r_points;
    logic [PHASEBITS-1:0]  r_freq;
    logic [PTBITS-1:0]     r_idx;
    logic                  r_done;
    logic                  r_error;
    logic                  r_abort_req;
    logic                  r_pend;
    logic                  r_m_wr;
    logic                  r_m_rd;
    logic [15:0]           r_m_addr;
    logic [31:0]           r_m_wdata;
    logic [30:0]           r_lo_i;
    logic [30:0]           r_hi_i;
    logic [30:0]           r_lo_q;
    logic [30:0]           r_hi_q;
    logic                  r_valid;
    logic                  r_ack;
    logic [31:0]           r_rdata;

    logic                  w_busy;
    logic                  w_wr_ctrl;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_m_done;
    logic                  w_m_tmo;
    logic [31:0]           w_m_rdata;

    assign w_busy    = (r_state != S_IDLE);
    assign w_wr_ctrl = wen && (addr == SL_CTRL);
    assign w_start   = w_wr_ctrl && wdata[0] && !wdata[1];
    assign w_abort   = r_abort_req || (w_wr_ctrl && wdata[1]);

    red_pitaya_na_bus_master #(.TOBITS(TOBITS)) u_bus_master (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .i_req_wr    (r_m_wr),
        .i_req_rd    (r_m_rd),
        .i_req_addr  (r_m_addr),
        .i_req_wdata (r_m_wdata),
        .o_done      (w_m_done),
        .o_timeout   (w_m_tmo),
        .o_rdata     (w_m_rdata),
        .o_iq_addr   (iq_addr),
        .o_iq_wen    (iq_wen),
        .o_iq_ren    (iq_ren),
        .o_iq_wdata  (iq_wdata),
        .i_iq_ack    (iq_ack),
        .i_iq_rdata  (iq_rdata)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ack        <= 1'b0;
            r_rdata      <= '0;
            r_start_freq <= '0;
            r_step_freq  <= '0;
            r_points     <= '0;
        end else begin
            r_ack <= wen || ren;
            if (ren) begin
                case (addr)
                    SL_STATUS:  r_rdata <= {29'b0, r_error, r_done, w_busy};
                    SL_START:   r_rdata <= 32'(r_start_freq);
                    SL_STEP:    r_rdata <= 32'(r_step_freq);
                    SL_POINTS:  r_rdata <= 32'(r_points);
                    SL_CUR_IDX: r_rdata <= 32'(r_idx);
                    default:    r_rdata <= '0;
                endcase
            end
            if (wen) begin
                case (addr)
                    SL_START:  r_start_freq <= wdata[PHASEBITS-1:0];
                    SL_STEP:   r_step_freq  <= wdata[PHASEBITS-1:0];
                    SL_POINTS: r_points     <= wdata[PTBITS-1:0];
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_freq      <= '0;
            r_idx       <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_abort_req <= 1'b0;
            r_pend      <= 1'b0;
            r_m_wr      <= 1'b0;
            r_m_rd      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_lo_i      <= '0;
            r_hi_i      <= '0;
            r_lo_q      <= '0;
            r_hi_q      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_m_wr      <= 1'b0;
            r_m_rd      <= 1'b0;
            r_abort_req <= w_busy && w_abort;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_error <= 1'b0;
                        if (r_points == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_done  <= 1'b0;
                            r_freq  <= r_start_freq;
                            r_idx   <= '0;
                            r_state <= S_SETF;
                        end
                    end
                end
                S_SETF, S_POLL, S_RIH, S_RQL, S_RQH: begin
                    if (!r_pend) begin
                        if (w_abort) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_pend    <= 1'b1;
                            r_m_wr    <= (r_state == S_SETF);
                            r_m_rd    <= (r_state != S_SETF);
                            r_m_addr  <= na_iq_addr(r_state);
                            r_m_wdata <= 32'(r_freq);
                        end
                    end else if (w_m_done) begin
                        r_pend <= 1'b0;
                        if (w_m_tmo) begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (w_abort) begin
                            r_state <= S_IDLE;
                        end else begin
                            case (r_state)
                                S_SETF: r_state <= S_POLL;
                                S_POLL: begin
                                    // bit 31 is do_averaging; stay and re-poll while set
                                    if (!w_m_rdata[31]) begin
                                        r_lo_i  <= w_m_rdata[30:0];
                                        r_state <= S_RIH;
                                    end
                                end
                                S_RIH: begin
                                    r_hi_i  <= w_m_rdata[30:0];
                                    r_state <= S_RQL;
                                end
                                S_RQL: begin
                                    r_lo_q  <= w_m_rdata[30:0];
                                    r_state <= S_RQH;
                                end
                                S_RQH: begin
                                    r_hi_q  <= w_m_rdata[30:0];
                                    r_valid <= 1'b1;
                                    r_state <= S_PUSH;
                                end
                                default: r_state <= S_IDLE;
                            endcase
                        end
                    end
                end
                S_PUSH: begin
                    if (w_abort) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (res_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_idx  <= r_idx + PTBITS'(1);
                        r_freq <= r_freq + r_step_freq;
                        if (r_idx == r_points - PTBITS'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_SETF;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign res_valid = r_valid;
    assign res_i     = SUMBITS'({r_hi_i, r_lo_i});
    assign res_q     = SUMBITS'({r_hi_q, r_lo_q});
    assign res_idx   = r_idx;
    assign busy_o    = w_busy;

endmodule
